// File: rtl/y86_pkg.sv
// Shared Y86 encodings for the decode stage: instruction codes, function
// codes, status codes and small decode helpers.
package y86_pkg;

    // Instruction codes
    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    // Default function code
    localparam logic [3:0] FNONE = 4'h0;

    // Pipeline status codes
    localparam logic [2:0] SAOK = 3'd1;
    localparam logic [2:0] SADR = 3'd2;
    localparam logic [2:0] SINS = 3'd3;
    localparam logic [2:0] SHLT = 3'd4;

    // Number of bypass sources feeding the operand network
    localparam int NBYP = 5;

    // Instructions whose result only exists after the memory stage
    function automatic logic is_load(input logic [3:0] icode);
        return (icode == IMRMOVQ) || (icode == IPOPQ);
    endfunction

endpackage

// File: rtl/y86_regfile.sv
// Y86 register file: two asynchronous read ports, two write ports at the
// rising edge. The M port wins when both ports target the same register.
// Register id RNONE (all ones) reads as zero and is never written.
module y86_regfile
    import y86_pkg::*;
#(
    parameter int               DATA_W     = 64,
    parameter int               REG_W      = 4,
    parameter int               RSP_ID     = 4,
    parameter logic [DATA_W-1:0] STACK_INIT = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_W-1:0]  src_a_i,
    input  logic [REG_W-1:0]  src_b_i,
    output logic [DATA_W-1:0] rd_a_o,
    output logic [DATA_W-1:0] rd_b_o,
    input  logic [REG_W-1:0]  w_dst_e_i,
    input  logic [DATA_W-1:0] w_val_e_i,
    input  logic [REG_W-1:0]  w_dst_m_i,
    input  logic [DATA_W-1:0] w_val_m_i
);

    localparam int              NREG  = 2**REG_W - 1;
    localparam logic [REG_W-1:0] RNONE = '1;

    logic [DATA_W-1:0] regs_q [NREG];

    // Register array: reset image, then E and M write-back (M written last so it wins)
    // NOTE: this array is built from flops, not a RAM macro, because software
    // depends on zeroed registers and a preset stack pointer after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= (i == RSP_ID) ? STACK_INIT : '0;
            end
        end else begin
            if (w_dst_e_i != RNONE) regs_q[w_dst_e_i] <= w_val_e_i;
            if (w_dst_m_i != RNONE) regs_q[w_dst_m_i] <= w_val_m_i;
        end
    end

    // Asynchronous reads; the unnamed register reads as zero
    always_comb begin
        rd_a_o = (src_a_i == RNONE) ? '0 : regs_q[src_a_i];
        rd_b_o = (src_b_i == RNONE) ? '0 : regs_q[src_b_i];
    end

endmodule

// File: rtl/y86_decode_stage.sv
// Y86 decode stage: source/destination selection, operand bypass, load-use
// interlock and the D->E pipeline register. Owns the register file.
// Build option DECODE_FWD_EN: when defined, operands are bypassed from
// E/M/W and only load-use stalls; when undefined, operands come from the
// register file alone and any pending write to a source stalls decode.
module y86_decode_stage
    import y86_pkg::*;
#(
    parameter int               DATA_W     = 64,
    parameter int               REG_W      = 4,
    parameter int               RSP_ID     = 4,
    parameter logic [DATA_W-1:0] STACK_INIT = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [2:0]        D_stat,
    input  logic [3:0]        D_icode,
    input  logic [3:0]        D_ifun,
    input  logic [REG_W-1:0]  D_rA,
    input  logic [REG_W-1:0]  D_rB,
    input  logic [DATA_W-1:0] D_valC,
    input  logic [DATA_W-1:0] D_valP,
    input  logic              E_bubble,
    input  logic [REG_W-1:0]  e_dstE,
    input  logic [DATA_W-1:0] e_valE,
    input  logic [REG_W-1:0]  M_dstE,
    input  logic [DATA_W-1:0] M_valE,
    input  logic [REG_W-1:0]  M_dstM,
    input  logic [DATA_W-1:0] m_valM,
    input  logic [REG_W-1:0]  W_dstE,
    input  logic [DATA_W-1:0] W_valE,
    input  logic [REG_W-1:0]  W_dstM,
    input  logic [DATA_W-1:0] W_valM,
    output logic              d_stall,
    output logic [2:0]        E_stat,
    output logic [3:0]        E_icode,
    output logic [3:0]        E_ifun,
    output logic [DATA_W-1:0] E_valC,
    output logic [DATA_W-1:0] E_valA,
    output logic [DATA_W-1:0] E_valB,
    output logic [REG_W-1:0]  E_dstE,
    output logic [REG_W-1:0]  E_dstM,
    output logic [REG_W-1:0]  E_srcA,
    output logic [REG_W-1:0]  E_srcB
);

    localparam logic [REG_W-1:0] RNONE = '1;
    localparam logic [REG_W-1:0] RSP   = REG_W'(RSP_ID);

    typedef struct packed {
        logic [2:0]        stat;
        logic [3:0]        icode;
        logic [3:0]        ifun;
        logic [DATA_W-1:0] val_c;
        logic [DATA_W-1:0] val_a;
        logic [DATA_W-1:0] val_b;
        logic [REG_W-1:0]  dst_e;
        logic [REG_W-1:0]  dst_m;
        logic [REG_W-1:0]  src_a;
        logic [REG_W-1:0]  src_b;
    } e_reg_t;

    localparam e_reg_t BUBBLE = '{stat: SAOK, icode: INOP, ifun: FNONE,
                                  val_c: '0, val_a: '0, val_b: '0,
                                  dst_e: RNONE, dst_m: RNONE,
                                  src_a: RNONE, src_b: RNONE};

    logic [REG_W-1:0]  src_a, src_b, dst_e, dst_m;
    logic [DATA_W-1:0] rf_a, rf_b, opnd_a, opnd_b, val_a;
    logic              hazard;
    logic [REG_W-1:0]  byp_dst [NBYP];
    e_reg_t            e_d, e_q;

    y86_regfile #(
        .DATA_W(DATA_W), .REG_W(REG_W), .RSP_ID(RSP_ID), .STACK_INIT(STACK_INIT)
    ) u_regfile (
        .clk(clk), .rst_n(rst_n),
        .src_a_i(src_a), .src_b_i(src_b),
        .rd_a_o(rf_a), .rd_b_o(rf_b),
        .w_dst_e_i(W_dstE), .w_val_e_i(W_valE),
        .w_dst_m_i(W_dstM), .w_val_m_i(W_valM)
    );

    // Bypass destinations in priority order (earliest pipeline stage first)
    assign byp_dst = '{e_dstE, M_dstM, M_dstE, W_dstM, W_dstE};

    // Source and destination register selection by instruction class
    // NOTE: combinational blocks use blocking '=' and give every output a
    // default first, so no path leaves a value unassigned (no latch).
    always_comb begin
        src_a = RNONE;
        src_b = RNONE;
        dst_e = RNONE;
        dst_m = RNONE;
        case (D_icode)
            IRRMOVQ: begin src_a = D_rA; src_b = D_rB; dst_e = D_rB; end
            IIRMOVQ: begin dst_e = D_rB; end
            IRMMOVQ: begin src_a = D_rA; src_b = D_rB; end
            IMRMOVQ: begin src_b = D_rB; dst_m = D_rA; end
            IOPQ:    begin src_a = D_rA; src_b = D_rB; dst_e = D_rB; end
            ICALL:   begin src_b = RSP;  dst_e = RSP; end
            IRET:    begin src_a = RSP;  src_b = RSP; dst_e = RSP; end
            IPUSHQ:  begin src_a = D_rA; src_b = RSP; dst_e = RSP; end
            IPOPQ:   begin src_a = RSP;  src_b = RSP; dst_e = RSP; dst_m = D_rA; end
            default: ;
        endcase
    end

`ifdef DECODE_FWD_EN
    logic [DATA_W-1:0] byp_val [NBYP];
    assign byp_val = '{e_valE, m_valM, M_valE, W_valM, W_valE};

    // First matching bypass source wins; RNONE never matches
    function automatic logic [DATA_W-1:0] fwd_sel(
        input logic [REG_W-1:0]  src,
        input logic [DATA_W-1:0] rf_val,
        input logic [REG_W-1:0]  dsts [NBYP],
        input logic [DATA_W-1:0] vals [NBYP]
    );
        for (int i = 0; i < NBYP; i++) begin
            if (src != RNONE && dsts[i] == src) return vals[i];
        end
        return rf_val;
    endfunction

    // Bypassed operands and load-use interlock
    always_comb begin
        opnd_a = fwd_sel(src_a, rf_a, byp_dst, byp_val);
        opnd_b = fwd_sel(src_b, rf_b, byp_dst, byp_val);
        hazard = is_load(e_q.icode) && (e_q.dst_m != RNONE) &&
                 ((e_q.dst_m == src_a) || (e_q.dst_m == src_b));
    end
`else
    logic unused_byp_vals;
    assign unused_byp_vals = ^{e_valE, M_valE, m_valM};

    // Register-file operands; stall while any source has a write in flight
    always_comb begin
        opnd_a = rf_a;
        opnd_b = rf_b;
        hazard = (e_q.dst_m != RNONE) &&
                 ((e_q.dst_m == src_a) || (e_q.dst_m == src_b));
        for (int i = 0; i < NBYP; i++) begin
            if (src_a != RNONE && byp_dst[i] == src_a) hazard = 1'b1;
            if (src_b != RNONE && byp_dst[i] == src_b) hazard = 1'b1;
        end
    end
`endif

    // valA carries the return/fall-through PC for CALL and jumps
    assign val_a   = (D_icode == ICALL || D_icode == IJXX) ? D_valP : opnd_a;
    assign d_stall = hazard;

    // Next E contents: a bubble on control request or interlock, else decoded values
    always_comb begin
        e_d = BUBBLE;
        if (!(E_bubble || hazard)) begin
            e_d.stat  = D_stat;
            e_d.icode = D_icode;
            e_d.ifun  = D_ifun;
            e_d.val_c = D_valC;
            e_d.val_a = val_a;
            e_d.val_b = opnd_b;
            e_d.dst_e = dst_e;
            e_d.dst_m = dst_m;
            e_d.src_a = src_a;
            e_d.src_b = src_b;
        end
    end

    // D->E pipeline register
    // NOTE: state registers use non-blocking '<=' so every flop samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) e_q <= BUBBLE;
        else        e_q <= e_d;
    end

    assign E_stat  = e_q.stat;
    assign E_icode = e_q.icode;
    assign E_ifun  = e_q.ifun;
    assign E_valC  = e_q.val_c;
    assign E_valA  = e_q.val_a;
    assign E_valB  = e_q.val_b;
    assign E_dstE  = e_q.dst_e;
    assign E_dstM  = e_q.dst_m;
    assign E_srcA  = e_q.src_a;
    assign E_srcB  = e_q.src_b;

endmodule

// File: tb/tb_y86_decode_stage.sv
// Self-checking bench for y86_decode_stage (DATA_W=64, REG_W=4, RSP_ID=4,
// STACK_INIT=0x100). Covers both DECODE_FWD_EN builds.
module tb_y86_decode_stage;
    import y86_pkg::*;

    localparam logic [3:0] RN = 4'hF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  D_stat = SAOK;
    logic [3:0]  D_icode = INOP, D_ifun = 4'h0, D_rA = RN, D_rB = RN;
    logic [63:0] D_valC = '0, D_valP = '0;
    logic        E_bubble = 1'b0;
    logic [3:0]  e_dstE = RN, M_dstE = RN, M_dstM = RN, W_dstE = RN, W_dstM = RN;
    logic [63:0] e_valE = '0, M_valE = '0, m_valM = '0, W_valE = '0, W_valM = '0;
    logic        d_stall;
    logic [2:0]  E_stat;
    logic [3:0]  E_icode, E_ifun, E_dstE, E_dstM, E_srcA, E_srcB;
    logic [63:0] E_valC, E_valA, E_valB;

    int n_checks = 0;
    int n_errors = 0;

    y86_decode_stage #(
        .DATA_W(64), .REG_W(4), .RSP_ID(4), .STACK_INIT(64'h100)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .D_stat(D_stat), .D_icode(D_icode), .D_ifun(D_ifun),
        .D_rA(D_rA), .D_rB(D_rB), .D_valC(D_valC), .D_valP(D_valP),
        .E_bubble(E_bubble),
        .e_dstE(e_dstE), .e_valE(e_valE),
        .M_dstE(M_dstE), .M_valE(M_valE),
        .M_dstM(M_dstM), .m_valM(m_valM),
        .W_dstE(W_dstE), .W_valE(W_valE),
        .W_dstM(W_dstM), .W_valM(W_valM),
        .d_stall(d_stall),
        .E_stat(E_stat), .E_icode(E_icode), .E_ifun(E_ifun),
        .E_valC(E_valC), .E_valA(E_valA), .E_valB(E_valB),
        .E_dstE(E_dstE), .E_dstM(E_dstM), .E_srcA(E_srcA), .E_srcB(E_srcB)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  stat;
        logic [3:0]  icode, ifun, ra, rb;
        logic [63:0] valc, valp, exp_vala, exp_valb;
        logic [3:0]  exp_dste, exp_dstm, exp_srca, exp_srcb;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_d(input logic [3:0] icode, input logic [3:0] ifun,
                         input logic [3:0] ra, input logic [3:0] rb,
                         input logic [63:0] valc, input logic [63:0] valp);
        D_stat = SAOK; D_icode = icode; D_ifun = ifun;
        D_rA = ra; D_rB = rb; D_valC = valc; D_valP = valp;
    endtask

    task automatic clear_byp();
        e_dstE = RN; M_dstE = RN; M_dstM = RN; W_dstE = RN; W_dstM = RN;
        e_valE = '0; M_valE = '0; m_valM = '0; W_valE = '0; W_valM = '0;
        E_bubble = 1'b0;
    endtask

    task automatic check_bubble(input string tag);
        check({tag, " icode"}, 64'(E_icode), 64'(INOP));
        check({tag, " stat"},  64'(E_stat),  64'(SAOK));
        check({tag, " dstE"},  64'(E_dstE),  64'(RN));
        check({tag, " dstM"},  64'(E_dstM),  64'(RN));
        check({tag, " srcA"},  64'(E_srcA),  64'(RN));
        check({tag, " valA"},  E_valA, 64'h0);
    endtask

    vec_t vecs [12];

    initial begin
        // Expected values assume regs r[i] = 0x1000+i (i != 4) and r4 = 0x100
        vecs[0]  = '{SAOK, IRRMOVQ, 4'h0, 4'h1, 4'h2, 64'h0,   64'h0,  64'h1001, 64'h1002, 4'h2, RN,   4'h1, 4'h2};
        vecs[1]  = '{SAOK, IIRMOVQ, 4'h0, RN,   4'h3, 64'h55,  64'h0,  64'h0,    64'h0,    4'h3, RN,   RN,   RN};
        vecs[2]  = '{SAOK, IRMMOVQ, 4'h0, 4'h5, 4'h6, 64'h10,  64'h0,  64'h1005, 64'h1006, RN,   RN,   4'h5, 4'h6};
        vecs[3]  = '{SAOK, IMRMOVQ, 4'h0, 4'h7, 4'h8, 64'h18,  64'h0,  64'h0,    64'h1008, RN,   4'h7, RN,   4'h8};
        vecs[4]  = '{SAOK, IOPQ,    4'h1, 4'h9, 4'hA, 64'h0,   64'h0,  64'h1009, 64'h100A, 4'hA, RN,   4'h9, 4'hA};
        vecs[5]  = '{SAOK, IJXX,    4'h3, RN,   RN,   64'h200, 64'h99, 64'h99,   64'h0,    RN,   RN,   RN,   RN};
        vecs[6]  = '{SAOK, ICALL,   4'h0, RN,   RN,   64'h300, 64'h40, 64'h40,   64'h100,  4'h4, RN,   RN,   4'h4};
        vecs[7]  = '{SAOK, IRET,    4'h0, RN,   RN,   64'h0,   64'h0,  64'h100,  64'h100,  4'h4, RN,   4'h4, 4'h4};
        vecs[8]  = '{SAOK, IPUSHQ,  4'h0, 4'hB, RN,   64'h0,   64'h0,  64'h100B, 64'h100,  4'h4, RN,   4'hB, 4'h4};
        vecs[9]  = '{SAOK, IPOPQ,   4'h0, 4'hC, RN,   64'h0,   64'h0,  64'h100,  64'h100,  4'h4, 4'hC, 4'h4, 4'h4};
        vecs[10] = '{SHLT, IHALT,   4'h0, 4'h1, 4'h2, 64'h0,   64'h0,  64'h0,    64'h0,    RN,   RN,   RN,   RN};
        vecs[11] = '{SADR, INOP,    4'h0, 4'h3, 4'h4, 64'h0,   64'h0,  64'h0,    64'h0,    RN,   RN,   RN,   RN};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_bubble("reset");
        check("reset stall", 64'(d_stall), 64'h0);
        #2 rst_n = 1'b1;

        // RRMOVQ from the stack pointer reads its reset value
        set_d(IRRMOVQ, 4'h0, 4'h4, 4'h2, 64'h0, 64'h0);
        tick();
        check("rrmov icode", 64'(E_icode), 64'(IRRMOVQ));
        check("rrmov valA",  E_valA, 64'h100);
        check("rrmov valB",  E_valB, 64'h0);
        check("rrmov dstE",  64'(E_dstE), 64'h2);

        // Preload registers through write-back port E
        set_d(INOP, 4'h0, RN, RN, 64'h0, 64'h0);
        for (int i = 0; i < 15; i++) begin
            if (i != 4) begin
                W_dstE = 4'(i);
                W_valE = 64'h1000 + 64'(i);
                tick();
            end
        end
        clear_byp();

        // Decode table
        for (int i = 0; i < 12; i++) begin
            D_stat = vecs[i].stat; D_icode = vecs[i].icode; D_ifun = vecs[i].ifun;
            D_rA = vecs[i].ra; D_rB = vecs[i].rb;
            D_valC = vecs[i].valc; D_valP = vecs[i].valp;
            #1;
            check($sformatf("v%0d stall", i), 64'(d_stall), 64'h0);
            tick();
            check($sformatf("v%0d stat", i),  64'(E_stat),  64'(vecs[i].stat));
            check($sformatf("v%0d icode", i), 64'(E_icode), 64'(vecs[i].icode));
            check($sformatf("v%0d ifun", i),  64'(E_ifun),  64'(vecs[i].ifun));
            check($sformatf("v%0d valC", i),  E_valC, vecs[i].valc);
            check($sformatf("v%0d valA", i),  E_valA, vecs[i].exp_vala);
            check($sformatf("v%0d valB", i),  E_valB, vecs[i].exp_valb);
            check($sformatf("v%0d dstE", i),  64'(E_dstE), 64'(vecs[i].exp_dste));
            check($sformatf("v%0d dstM", i),  64'(E_dstM), 64'(vecs[i].exp_dstm));
            check($sformatf("v%0d srcA", i),  64'(E_srcA), 64'(vecs[i].exp_srca));
            check($sformatf("v%0d srcB", i),  64'(E_srcB), 64'(vecs[i].exp_srcb));
        end

        // Dual write to the same register: M port wins
        set_d(INOP, 4'h0, RN, RN, 64'h0, 64'h0);
        W_dstE = 4'h5; W_valE = 64'hA; W_dstM = 4'h5; W_valM = 64'hB;
        tick();
        clear_byp();
        set_d(IOPQ, 4'h0, 4'h1, 4'h5, 64'h0, 64'h0);
        tick();
        check("wb prio valB", E_valB, 64'hB);
        check("wb prio valA", E_valA, 64'h1001);

        // CALL with a simultaneous bubble request
        set_d(ICALL, 4'h0, RN, RN, 64'h0, 64'h40);
        E_bubble = 1'b1;
        #1;
        check("call bubble stall", 64'(d_stall), 64'h0);
        tick();
        check("call bubble icode", 64'(E_icode), 64'(INOP));
        check("call bubble dstE",  64'(E_dstE),  64'(RN));
        E_bubble = 1'b0;

`ifdef DECODE_FWD_EN
        // Forward priority: e over M, and W_valM over W_valE
        set_d(IOPQ, 4'h0, 4'h1, 4'h2, 64'h0, 64'h0);
        e_dstE = 4'h1; e_valE = 64'h7; M_dstE = 4'h1; M_valE = 64'h9;
        W_dstM = 4'h2; W_valM = 64'h33; W_dstE = 4'h2; W_valE = 64'h44;
        tick();
        check("fwd e>M valA", E_valA, 64'h7);
        check("fwd Wm>We valB", E_valB, 64'h33);
        clear_byp();

        // M_valE beats W_valM; lone W_valE beats the register file
        set_d(IOPQ, 4'h0, 4'h6, 4'h7, 64'h0, 64'h0);
        W_dstE = 4'h6; W_valE = 64'h66; M_dstE = 4'h7; M_valE = 64'h77;
        W_dstM = 4'h7; W_valM = 64'h88;
        tick();
        check("fwd We valA", E_valA, 64'h66);
        check("fwd M>W valB", E_valB, 64'h77);
        clear_byp();

        // RNONE source never matches a RNONE bypass id
        set_d(IIRMOVQ, 4'h0, RN, 4'h3, 64'h5, 64'h0);
        e_valE = 64'h77; M_valE = 64'h78;
        tick();
        check("rnone valA", E_valA, 64'h0);
        check("rnone valB", E_valB, 64'h0);
        clear_byp();

        // Load-use: one bubble, then the loaded value is bypassed from m_valM
        set_d(IMRMOVQ, 4'h0, 4'h3, RN, 64'h0, 64'h0);
        tick();
        set_d(IOPQ, 4'h0, 4'h3, 4'h1, 64'h0, 64'h0);
        #1;
        check("load-use stall", 64'(d_stall), 64'h1);
        tick();
        check("load-use bubble", 64'(E_icode), 64'(INOP));
        M_dstM = 4'h3; m_valM = 64'h5A;
        #1;
        check("load-use release", 64'(d_stall), 64'h0);
        tick();
        check("load-use icode", 64'(E_icode), 64'(IOPQ));
        check("load-use valA", E_valA, 64'h5A);
        check("load-use valB", E_valB, 64'h1001);
        clear_byp();
`else
        // No bypass: stall through E, M and W, then read the written value
        set_d(IIRMOVQ, 4'h0, RN, 4'h2, 64'h77, 64'h0);
        tick();
        set_d(IRRMOVQ, 4'h0, 4'h2, 4'h3, 64'h0, 64'h0);
        e_dstE = 4'h2; e_valE = 64'h77;
        #1;
        check("nofwd stall e", 64'(d_stall), 64'h1);
        tick();
        check("nofwd bubble", 64'(E_icode), 64'(INOP));
        e_dstE = RN; M_dstE = 4'h2; M_valE = 64'h77;
        #1;
        check("nofwd stall M", 64'(d_stall), 64'h1);
        tick();
        M_dstE = RN; W_dstE = 4'h2; W_valE = 64'h77;
        #1;
        check("nofwd stall W", 64'(d_stall), 64'h1);
        tick();
        check("nofwd bubble W", 64'(E_icode), 64'(INOP));
        clear_byp();
        #1;
        check("nofwd release", 64'(d_stall), 64'h0);
        tick();
        check("nofwd icode", 64'(E_icode), 64'(IRRMOVQ));
        check("nofwd valA", E_valA, 64'h77);
        check("nofwd valB", E_valB, 64'h1003);
`endif

        // Bubble request and load-use together: one bubble, stall still high
        set_d(IMRMOVQ, 4'h0, 4'h3, RN, 64'h0, 64'h0);
        tick();
        set_d(IOPQ, 4'h0, 4'h3, 4'h1, 64'h0, 64'h0);
        E_bubble = 1'b1;
        #1;
        check("bub+haz stall", 64'(d_stall), 64'h1);
        tick();
        check("bub+haz icode", 64'(E_icode), 64'(INOP));
        E_bubble = 1'b0;

        // Asynchronous reset in the middle of a stall
        set_d(IMRMOVQ, 4'h0, 4'h3, RN, 64'h0, 64'h0);
        tick();
        check("pre-rst dstM", 64'(E_dstM), 64'h3);
        set_d(IOPQ, 4'h0, 4'h3, 4'h1, 64'h0, 64'h0);
        #1;
        check("pre-rst stall", 64'(d_stall), 64'h1);
        rst_n = 1'b0;
        #1;
        check_bubble("mid-rst");
        check("mid-rst stall", 64'(d_stall), 64'h0);
        #1 rst_n = 1'b1;

        // Register file back to its reset image
        set_d(IRRMOVQ, 4'h0, 4'h3, 4'h4, 64'h0, 64'h0);
        tick();
        check("post-rst valA", E_valA, 64'h0);
        check("post-rst valB", E_valB, 64'h100);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
